// File: rtl/tp_div_pkg.sv
// -----------------------------------------------------------------------------
// tp_div_pkg
// Shared constants for the sequential signed divider tp_div_33s_17s_18s_seq:
// default operand widths, quotient saturation limits, the number of
// restoring-division iterations and the controller state encoding.
// -----------------------------------------------------------------------------
package tp_div_pkg;

   localparam int TP_DIV_DIVIDEND_W = 33;
   localparam int TP_DIV_DIVISOR_W  = 17;
   localparam int TP_DIV_QUOTIENT_W = 18;

   // Signed 18-bit quotient range.
   localparam int TP_DIV_SAT_POS = 131071;
   localparam int TP_DIV_SAT_NEG = -131072;

   // One quotient bit per dividend bit.
   localparam int TP_DIV_NUM_ITER = 33;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } tp_div_state_e;

endpackage

// File: rtl/tp_div_udiv_step.sv
// -----------------------------------------------------------------------------
// tp_div_udiv_step
// One unsigned restoring-division iteration (purely combinational).
// The partial remainder is shifted left by one, the next dividend bit enters
// at the LSB, and the divisor is trial-subtracted. If the trial does not go
// negative the difference is kept and the quotient bit is 1, otherwise the
// shifted value is restored and the quotient bit is 0.
//
// Ports:
//   rem_i  partial remainder in   (always < div_i when div_i != 0)
//   bit_i  next dividend bit, MSB first
//   div_i  divisor magnitude
//   rem_o  partial remainder out
//   q_o    quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module tp_div_udiv_step #(
   parameter int DVW = 17
) (
   input  logic [DVW-1:0] rem_i,
   input  logic           bit_i,
   input  logic [DVW-1:0] div_i,
   output logic [DVW-1:0] rem_o,
   output logic           q_o
);

   logic [DVW:0] part;

   assign part  = {rem_i, bit_i};
   assign q_o   = (part >= {1'b0, div_i});
   // The kept result is always below the divisor, so it fits in DVW bits.
   assign rem_o = DVW'(part - (q_o ? {1'b0, div_i} : '0));

endmodule

// File: rtl/tp_div_33s_17s_18s_seq.sv
// -----------------------------------------------------------------------------
// tp_div_33s_17s_18s_seq
// Sequential signed divider: 33-bit signed dividend / 17-bit signed divisor,
// saturated 18-bit signed quotient truncated toward zero. Operand magnitudes
// are divided by an unsigned restoring divider, one quotient bit per cycle,
// then the sign is applied and the result saturated in a final FIX cycle.
// Fixed latency 35 cycles from accept to ap_done, initiation interval 36.
//
// Ports:
//   ap_clk    clock, rising edge
//   ap_rst    synchronous active-high reset (wins over ap_start)
//   ap_start  start request, honoured only while idle
//   ap_idle   high in IDLE
//   ap_ready  high in the cycle a start is accepted
//   ap_done   one-cycle pulse when dout/ovf (and rem) are valid
//   din0      signed dividend, sampled on accept
//   din1      signed divisor, sampled on accept
//   dout      signed quotient, held until the next operation's FIX cycle
//   ovf       set on saturation or divide-by-zero
//   rem       (TP_DIV_REMAINDER_EN only) signed remainder, dividend's sign
//
// Build option: define TP_DIV_REMAINDER_EN to add the rem output.
// -----------------------------------------------------------------------------
module tp_div_33s_17s_18s_seq
   import tp_div_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = TP_DIV_DIVIDEND_W,
   parameter int DIVISOR_WIDTH  = TP_DIV_DIVISOR_W,
   parameter int QUOTIENT_WIDTH = TP_DIV_QUOTIENT_W
) (
   input  logic                             ap_clk,
   input  logic                             ap_rst,
   input  logic                             ap_start,
   output logic                             ap_idle,
   output logic                             ap_ready,
   output logic                             ap_done,
   input  logic signed [DIVIDEND_WIDTH-1:0] din0,
   input  logic signed [DIVISOR_WIDTH-1:0]  din1,
   output logic signed [QUOTIENT_WIDTH-1:0] dout,
   output logic                             ovf
`ifdef TP_DIV_REMAINDER_EN
   ,
   output logic signed [DIVISOR_WIDTH-1:0]  rem
`endif
);

   localparam int CNT_W = $clog2(TP_DIV_NUM_ITER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TP_DIV_NUM_ITER - 1);

   // Largest quotient magnitudes representable for each sign.
   localparam logic [DIVIDEND_WIDTH-1:0] MAG_POS = DIVIDEND_WIDTH'(TP_DIV_SAT_POS);
   localparam logic [DIVIDEND_WIDTH-1:0] MAG_NEG = DIVIDEND_WIDTH'(-TP_DIV_SAT_NEG);
   localparam logic [QUOTIENT_WIDTH-1:0] Q_POS   = QUOTIENT_WIDTH'(TP_DIV_SAT_POS);
   localparam logic [QUOTIENT_WIDTH-1:0] Q_NEG   = QUOTIENT_WIDTH'(TP_DIV_SAT_NEG);

   tp_div_state_e state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   // a_q starts as |dividend| and shifts left each CALC cycle; quotient bits
   // enter at the LSB, so after the last iteration it holds the quotient.
   logic [DIVIDEND_WIDTH-1:0] a_q, a_d;
   logic [DIVISOR_WIDTH-1:0]  r_q, r_d;
   logic [DIVISOR_WIDTH-1:0]  b_q, b_d;
   logic                      sa_q, sa_d;
   logic                      sb_q, sb_d;
   logic [QUOTIENT_WIDTH-1:0] dout_q, dout_d;
   logic                      ovf_q, ovf_d;
`ifdef TP_DIV_REMAINDER_EN
   logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
`endif

   logic [DIVISOR_WIDTH-1:0]  step_rem;
   logic                      step_q;
   logic                      neg;
   logic [QUOTIENT_WIDTH-1:0] q_lo;

   tp_div_udiv_step #(
      .DVW (DIVISOR_WIDTH)
   ) u_step (
      .rem_i (r_q),
      .bit_i (a_q[DIVIDEND_WIDTH-1]),
      .div_i (b_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   assign neg  = sa_q ^ sb_q;
   assign q_lo = a_q[QUOTIENT_WIDTH-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      r_d     = r_q;
      b_d     = b_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      dout_d  = dout_q;
      ovf_d   = ovf_q;
`ifdef TP_DIV_REMAINDER_EN
      rem_d   = rem_q;
`endif
      case (state_q)
         IDLE: begin
            if (ap_start) begin
               state_d = CALC;
               cnt_d   = '0;
               sa_d    = din0[DIVIDEND_WIDTH-1];
               sb_d    = din1[DIVISOR_WIDTH-1];
               // Magnitudes are unsigned, so -2^32 and -65536 are exact.
               a_d     = din0[DIVIDEND_WIDTH-1] ? unsigned'(-din0) : unsigned'(din0);
               b_d     = din1[DIVISOR_WIDTH-1]  ? unsigned'(-din1) : unsigned'(din1);
               r_d     = '0;
            end
         end
         CALC: begin
            a_d   = {a_q[DIVIDEND_WIDTH-2:0], step_q};
            r_d   = step_rem;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = FIX;
         end
         FIX: begin
            state_d = DONE;
            if (b_q == '0) begin
               ovf_d  = 1'b1;
               dout_d = sa_q ? Q_NEG : Q_POS;
            end else if (!neg && (a_q > MAG_POS)) begin
               ovf_d  = 1'b1;
               dout_d = Q_POS;
            end else if (neg && (a_q > MAG_NEG)) begin
               ovf_d  = 1'b1;
               dout_d = Q_NEG;
            end else begin
               ovf_d  = 1'b0;
               dout_d = neg ? (~q_lo + 1'b1) : q_lo;
            end
`ifdef TP_DIV_REMAINDER_EN
            // Remainder follows the dividend's sign; unaffected by saturation.
            if (b_q == '0) rem_d = '0;
            else           rem_d = sa_q ? (~r_q + 1'b1) : r_q;
`endif
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         r_q     <= '0;
         b_q     <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dout_q  <= '0;
         ovf_q   <= 1'b0;
`ifdef TP_DIV_REMAINDER_EN
         rem_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         r_q     <= r_d;
         b_q     <= b_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dout_q  <= dout_d;
         ovf_q   <= ovf_d;
`ifdef TP_DIV_REMAINDER_EN
         rem_q   <= rem_d;
`endif
      end
   end

   assign ap_idle  = (state_q == IDLE);
   assign ap_done  = (state_q == DONE);
   // Accept is decided in the same cycle start is seen; reset blocks it.
   assign ap_ready = (state_q == IDLE) && ap_start && !ap_rst;
   assign dout     = dout_q;
   assign ovf      = ovf_q;
`ifdef TP_DIV_REMAINDER_EN
   assign rem      = rem_q;
`endif

endmodule

// File: tb/tb_tp_div_33s_17s_18s_seq.sv
module tb_tp_div_33s_17s_18s_seq;

   logic               ap_clk = 1'b0;
   logic               ap_rst;
   logic               ap_start;
   logic               ap_idle, ap_ready, ap_done;
   logic signed [32:0] din0;
   logic signed [16:0] din1;
   logic signed [17:0] dout;
   logic               ovf;
`ifdef TP_DIV_REMAINDER_EN
   logic signed [16:0] rem;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   tp_div_33s_17s_18s_seq dut (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .ap_start (ap_start),
      .ap_idle  (ap_idle),
      .ap_ready (ap_ready),
      .ap_done  (ap_done),
      .din0     (din0),
      .din1     (din1),
      .dout     (dout),
      .ovf      (ovf)
`ifdef TP_DIV_REMAINDER_EN
      ,
      .rem      (rem)
`endif
   );

   initial forever #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference: exact integer division, then range clamp.
   task automatic model(input longint a, input longint b,
                        output logic signed [17:0] q, output logic o,
                        output logic signed [16:0] r);
      longint qt;
      if (b == 0) begin
         o = 1'b1;
         q = (a >= 0) ? 18'sd131071 : -18'sd131072;
         r = '0;
      end else begin
         qt = a / b;
         r  = 17'(a % b);
         if (qt > 131071)       begin q = 18'sd131071;  o = 1'b1; end
         else if (qt < -131072) begin q = -18'sd131072; o = 1'b1; end
         else                   begin q = 18'(qt);      o = 1'b0; end
      end
   endtask

   task automatic do_div(input logic signed [32:0] a, input logic signed [16:0] b);
      logic signed [17:0] eq;
      logic               eo;
      logic signed [16:0] er;
      int                 lat;
      model(longint'(a), longint'(b), eq, eo, er);
      @(negedge ap_clk);
      chk("idle_before", ap_idle, 1);
      din0 = a; din1 = b; ap_start = 1'b1;
      #1;
      chk("ready_on_accept", ap_ready, 1);
      @(posedge ap_clk);
      #1;
      ap_start = 1'b0;
      din0 = 33'($urandom);
      din1 = 17'($urandom);
      lat = 0;
      while (lat < 50) begin
         @(negedge ap_clk);
         lat++;
         if (ap_done) break;
      end
      chk("latency", lat, 35);
      chk("dout", dout, eq);
      chk("ovf", ovf, eo);
`ifdef TP_DIV_REMAINDER_EN
      chk("rem", rem, er);
`endif
      @(negedge ap_clk);
      chk("done_pulse_width", ap_done, 0);
      chk("dout_held", dout, eq);
   endtask

   initial begin
      logic [63:0] t;
      int          x;
      int          seen;
      logic signed [32:0] ra;
      logic signed [16:0] rb;

      // Reset with start asserted: reset must win.
      ap_rst = 1'b1; ap_start = 1'b1; din0 = 33'sd100; din1 = 17'sd3;
      repeat (3) @(negedge ap_clk);
      #1;
      chk("ready_in_reset", ap_ready, 0);
      ap_rst = 1'b0; ap_start = 1'b0;
      chk("rst_idle", ap_idle, 1);
      chk("rst_done", ap_done, 0);
      chk("rst_dout", dout, 0);
      chk("rst_ovf", ovf, 0);
`ifdef TP_DIV_REMAINDER_EN
      chk("rst_rem", rem, 0);
`endif

      // Directed cases.
      do_div(33'sd1000000, 17'sd1000);
      do_div(-33'sd7, 17'sd2);
      do_div(33'sd2147483648, 17'sd1);
      do_div(-33'sd4294967296, -17'sd65536);
      do_div(-33'sd5, 17'sd0);
      do_div(33'sd5, 17'sd0);
      do_div(33'sd131072, -17'sd1);
      do_div(-33'sd131073, 17'sd1);
      do_div(33'sd4294967295, 17'sd65535);

      // Randomized operands: mix of full-range and small magnitudes.
      for (int i = 0; i < 40; i++) begin
         t = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 0) ra = t[32:0];
         else begin
            x  = int'($urandom_range(0, 2097152)) - 1048576;
            ra = 33'(x);
         end
         case ($urandom_range(0, 3))
            0:       rb = t[48:32];
            1:       rb = 17'(int'($urandom_range(0, 600)) - 300);
            2:       rb = 17'(int'($urandom_range(0, 20)) - 10);
            default: rb = '0;
         endcase
         do_div(ra, rb);
      end

      // Reset during CALC aborts the operation.
      @(negedge ap_clk);
      din0 = 33'sd999999; din1 = 17'sd7; ap_start = 1'b1;
      @(posedge ap_clk);
      #1 ap_start = 1'b0;
      repeat (10) @(negedge ap_clk);
      ap_rst = 1'b1;
      @(negedge ap_clk);
      ap_rst = 1'b0;
      chk("abort_idle", ap_idle, 1);
      chk("abort_dout", dout, 0);
      chk("abort_ovf", ovf, 0);
      seen = 0;
      repeat (40) begin
         @(negedge ap_clk);
         if (ap_done) seen++;
      end
      chk("abort_no_done", seen, 0);

      // Start held high: back-to-back operations every 36 cycles.
      @(negedge ap_clk);
      din0 = -33'sd123456; din1 = 17'sd10; ap_start = 1'b1;
      for (int c = 0; c < 80; c++) begin
         #1;
         chk("hold_ready", ap_ready, (c % 36 == 0));
         chk("hold_done", ap_done, (c == 35 || c == 71));
         if (c == 35) chk("hold_dout", dout, -18'sd12345);
         @(negedge ap_clk);
      end
      ap_start = 1'b0;
      seen = 0;
      for (int c = 0; c < 60 && seen == 0; c++) begin
         @(negedge ap_clk);
         if (ap_done) seen = 1;
      end
      chk("hold_third_done", seen, 1);
      chk("hold_third_dout", dout, -18'sd12345);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tp_div_33s_17s_18s_seq.md
TP_DIV_33S_17S_18S_SEQ -- requirements
Module: tp_div_33s_17s_18s_seq

Interface
REQ-001 SHALL have parameter DIVIDEND_WIDTH, default 33, signed dividend width.
REQ-002 SHALL have parameter DIVISOR_WIDTH, default 17, signed divisor width.
REQ-003 SHALL have parameter QUOTIENT_WIDTH, default 18, signed quotient width.
REQ-004 SHALL have port ap_clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port ap_rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port ap_start, input, 1, request to start a division.
REQ-007 SHALL have port ap_idle, output, 1, high when in IDLE.
REQ-008 SHALL have port ap_ready, output, 1, high in the cycle a start is accepted.
REQ-009 SHALL have port ap_done, output, 1, one-cycle pulse when results are valid.
REQ-010 SHALL have port din0, input, DIVIDEND_WIDTH, signed dividend; sampled only on accept.
REQ-011 SHALL have port din1, input, DIVISOR_WIDTH, signed divisor; sampled only on accept.
REQ-012 SHALL have port dout, output, QUOTIENT_WIDTH, signed quotient.
REQ-013 SHALL have port ovf, output, 1, saturation or divide-by-zero flag.

Function
REQ-014 SHALL use states IDLE, CALC, FIX, DONE; IDLE->CALC on ap_start, CALC->FIX after 33 iterations, FIX->DONE, DONE->IDLE unconditionally.
REQ-015 SHALL accept ap_start only in IDLE; ap_start in any other state is ignored and not queued.
REQ-016 SHALL, on accept at cycle N, register |din0|, |din1| and both signs, and assert ap_ready in cycle N only.
REQ-017 SHALL perform unsigned restoring division, one quotient bit per CALC cycle, MSB first, over cycles N+1..N+33.
REQ-018 SHALL, in FIX (cycle N+34), apply sign (quotient negative iff signs differ; truncation toward zero) and saturate.
REQ-019 SHALL assert ap_done in cycle N+35 only, with dout/ovf valid from that cycle; fixed latency 35 cycles, initiation interval 36 cycles.
REQ-020 SHALL hold dout/ovf stable from ap_done until the FIX cycle of the next operation.
REQ-021 SHALL saturate to +131071 (positive) or -131072 (negative) and set ovf=1 when the true quotient is out of range.
REQ-022 SHALL, on divisor 0, run the full 35 cycles, set dout=+131071 if din0>=0 else -131072, and set ovf=1.
REQ-023 SHALL handle din0=-2^32 and din1=-65536 without internal overflow; the magnitude registers are 33 and 17 bits unsigned.

Reset
REQ-024 SHALL, on ap_rst, enter IDLE and set dout=0, ovf=0, ap_done=0, ap_ready=0, ap_idle=1 at the next edge.
REQ-025 SHALL abort any operation in progress on reset; no ap_done is issued for it.
REQ-026 SHALL give ap_rst priority over a simultaneous ap_start.

Configuration
REQ-027 SHALL, with TP_DIV_REMAINDER_EN defined, add output port rem (DIVISOR_WIDTH, signed) carrying din0 - q_true*din1, with the sign of the dividend.
REQ-028 SHALL compute rem from the unsaturated quotient; rem=0 on divide-by-zero; rem resets to 0 and is valid and held with dout.
REQ-029 SHALL, without TP_DIV_REMAINDER_EN, have no rem port and no remainder sign-fix logic.

Structure
REQ-030 SHALL place width constants, saturation limits (+131071/-131072), the iteration count 33 and the state enum in package tp_div_pkg.
REQ-031 SHALL instantiate one combinational sub-module, tp_div_udiv_step: one shift/trial-subtract/restore iteration.

Verification
REQ-032 SHALL cover: start din0=1000000, din1=1000 at N -> ap_done at N+35, dout=1000, ovf=0, rem=0.
REQ-033 SHALL cover: din0=-7, din1=2 -> dout=-3, rem=-1, ovf=0.
REQ-034 SHALL cover: din0=2^31, din1=1 -> dout=131071, ovf=1; din0=-2^32, din1=-65536 -> dout=65536, ovf=0.
REQ-035 SHALL cover: din0=-5, din1=0 -> dout=-131072, ovf=1, rem=0, latency 35.
REQ-036 SHALL cover: ap_rst at CALC cycle 10 -> ap_idle=1 next cycle, dout=0, no ap_done within 40 cycles.
REQ-037 SHALL cover: ap_start held high continuously -> ap_ready at N, N+36, N+72; ap_done at N+35, N+71.
